// File: rtl/fir4_chan_sched.sv
// Round-robin multi-channel scheduler feeding a shared 4-tap FIR sum, 2-cycle latency, full output backpressure.
// Optional macro FIR4_SCHED_AVG_EN: out_sum becomes floor(sum/4) instead of the raw sum.
module fir4_chan_sched #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*W-1:0]      in_data,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH-1:0]        clr_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHW-1:0]        out_ch,
  output logic signed [W+1:0]   out_sum
);

  function automatic logic [CHW-1:0] wrap_ch(input int v);
    return CHW'(v % NCH);
  endfunction

  logic [CHW-1:0]        ptr;
  logic [CHW-1:0]        gnt_ch;
  logic                  gnt_any;
  logic                  stall;
  logic                  accept;
  logic                  clr_gnt;
  logic signed [W-1:0]   x;
  logic signed [W-1:0]   tap1_nxt, tap2_nxt, tap3_nxt;
  logic signed [W-1:0]   h0 [NCH];
  logic signed [W-1:0]   h1 [NCH];
  logic signed [W-1:0]   h2 [NCH];

  logic                  v1;
  logic [CHW-1:0]        ch1;
  logic signed [W-1:0]   tap0, tap1, tap2, tap3;
  logic signed [W+1:0]   sum;
  logic signed [W+1:0]   res;

  assign stall = out_valid && !out_ready;

  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (in_valid[wrap_ch(int'(ptr) + k)]) begin
        gnt_any = 1'b1;
        gnt_ch  = wrap_ch(int'(ptr) + k);
      end
    end
  end

  assign accept = gnt_any && !stall && !reset;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt_ch] = 1'b1;
  end

  assign x        = in_data[int'(gnt_ch)*W +: W];
  assign clr_gnt  = clr_ch[gnt_ch];
  assign tap1_nxt = clr_gnt ? '0 : h0[gnt_ch];
  assign tap2_nxt = clr_gnt ? '0 : h1[gnt_ch];
  assign tap3_nxt = clr_gnt ? '0 : h2[gnt_ch];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  // Clear acts even while stalled; on a same-edge accept it wipes only the old history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        h0[i] <= '0;
        h1[i] <= '0;
        h2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept && gnt_ch == CHW'(i)) begin
          h0[i] <= x;
          h1[i] <= clr_ch[i] ? '0 : h0[i];
          h2[i] <= clr_ch[i] ? '0 : h1[i];
        end else if (clr_ch[i]) begin
          h0[i] <= '0;
          h1[i] <= '0;
          h2[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      ch1  <= '0;
      tap0 <= '0;
      tap1 <= '0;
      tap2 <= '0;
      tap3 <= '0;
    end else if (!stall) begin
      v1   <= accept;
      ch1  <= gnt_ch;
      tap0 <= x;
      tap1 <= tap1_nxt;
      tap2 <= tap2_nxt;
      tap3 <= tap3_nxt;
    end
  end

  assign sum = {{2{tap0[W-1]}}, tap0} + {{2{tap1[W-1]}}, tap1}
             + {{2{tap2[W-1]}}, tap2} + {{2{tap3[W-1]}}, tap3};

`ifdef FIR4_SCHED_AVG_EN
  assign res = sum >>> 2;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      out_ch    <= ch1;
      out_sum   <= res;
    end
  end

endmodule

// File: tb/tb_fir4_chan_sched.sv
// Scoreboard bench for fir4_chan_sched: per-channel history model, round-robin grant model, directed result lists.
module tb_fir4_chan_sched;
  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NCH-1:0]      in_valid = '0;
  logic [NCH*W-1:0]    in_data = '0;
  logic [NCH-1:0]      in_ready;
  logic [NCH-1:0]      clr_ch = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CHW-1:0]      out_ch;
  logic signed [W+1:0] out_sum;

  fir4_chan_sched #(.W(W), .NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int ch; int sum; int cyc; int st;} exp_t;
  exp_t sb[$];
  int   got_q[$];
  int   last_sum[NCH];
  int   hist[NCH][3];
  int   m_ptr = 0;
  int   stall_cnt = 0;
  int   cyc = 0;
  logic prev_stall = 1'b0;
  logic prev_rst = 1'b1;
  logic [CHW-1:0]      prev_ch = '0;
  logic signed [W+1:0] prev_sum = '0;

  always @(posedge clk) cyc++;

  // Monitor: checks grants and holds, pops results, and pushes expectations for accepted samples.
  always @(negedge clk) begin
    logic stall;
    logic [NCH-1:0] exp_rdy;
    logic signed [W-1:0] xs;
    int vmask, amask, cmask, idx, x, s;
    exp_t e;
    if (reset) begin
      check("rst_in_ready", int'(in_ready), 0);
      if (prev_rst) begin
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_sum", int'(out_sum), 0);
      end
      sb.delete();
      for (int i = 0; i < NCH; i++)
        for (int j = 0; j < 3; j++) hist[i][j] = 0;
      m_ptr = 0;
      prev_stall = 1'b0;
    end else begin
      stall = out_valid && !out_ready;
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_ch", int'(out_ch), int'(prev_ch));
        check("hold_sum", int'(out_sum), int'(prev_sum));
      end
      vmask = int'(in_valid);
      exp_rdy = '0;
      if (!stall) begin
        for (int k = NCH - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % NCH;
          if (((vmask >> idx) & 1) != 0) exp_rdy = NCH'(1) << idx;
        end
      end
      check("in_ready", int'(in_ready), int'(exp_rdy));
      if (stall) stall_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_ch", int'(out_ch), e.ch);
          check("out_sum", int'(out_sum), e.sum);
          check("latency", cyc - e.cyc, 2 + stall_cnt - e.st);
          got_q.push_back(int'(out_sum));
          last_sum[e.ch] = int'(out_sum);
        end
      end
      amask = int'(in_valid & in_ready);
      cmask = int'(clr_ch);
      for (int i = 0; i < NCH; i++) begin
        if (((cmask >> i) & 1) != 0) begin
          for (int j = 0; j < 3; j++) hist[i][j] = 0;
        end
        if (((amask >> i) & 1) != 0) begin
          xs = W'(in_data >> (i * W));
          x  = int'(xs);
          s  = x + hist[i][0] + hist[i][1] + hist[i][2];
`ifdef FIR4_SCHED_AVG_EN
          s = s >>> 2;
`endif
          sb.push_back('{ch: i, sum: s, cyc: cyc, st: stall_cnt});
          hist[i][2] = hist[i][1];
          hist[i][1] = hist[i][0];
          hist[i][0] = x;
          m_ptr = (i + 1) % NCH;
        end
      end
      prev_stall = stall;
      prev_ch    = out_ch;
      prev_sum   = out_sum;
    end
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input int val);
    logic [NCH*W-1:0] mask, word;
    mask    = (NCH*W)'({W{1'b1}}) << (c * W);
    word    = (NCH*W)'(W'(val)) << (c * W);
    in_data = (in_data & ~mask) | word;
  endtask

  task automatic send(input int c, input int val, input bit clr);
    bit done;
    done = 1'b0;
    set_data(c, val);
    in_valid = in_valid | (NCH'(1) << c);
    if (clr) clr_ch = clr_ch | (NCH'(1) << c);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = ((int'(in_ready) >> c) & 1) != 0;
      tick();
      clr_ch = '0;
    end
    in_valid = in_valid & ~(NCH'(1) << c);
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic cmp_list(input string tag, input int exp[$]);
    check({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check(tag, got_q[i], exp[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int e[$];
    bit seen;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single-channel ramp
    got_q.delete();
    for (int v = 1; v <= 5; v++) send(0, v, 1'b0);
    drain();
    e = '{1, 3, 6, 10, 14};
`ifndef FIR4_SCHED_AVG_EN
    cmp_list("ramp", e);
`endif

    // Fairness and isolation, from a fresh pointer
    do_reset();
    tick();
    in_data  = {16'h8000, 16'h7FFF, 16'hFFF9, 16'd100};
    in_valid = '1;
    repeat (20) tick();
    in_valid = '0;
    drain();
`ifndef FIR4_SCHED_AVG_EN
    check("fair_ch0", last_sum[0], 400);
    check("fair_ch1", last_sum[1], -28);
    check("fair_ch2", last_sum[2], 131068);
    check("fair_ch3", last_sum[3], -131072);
`endif

    // Backpressure on ch0
    clr_ch = 4'b0001;
    tick();
    clr_ch = '0;
    got_q.delete();
    fork
      for (int v = 1; v <= 6; v++) send(0, v, 1'b0);
      begin
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
          @(negedge clk);
          seen = out_valid;
        end
        if (!seen) check("bp_wait_timeout", 0, 1);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    e = '{1, 3, 6, 10, 14, 18};
`ifndef FIR4_SCHED_AVG_EN
    cmp_list("bp", e);
`endif

    // Clear colliding with acceptance on ch1
    clr_ch = 4'b0010;
    tick();
    clr_ch = '0;
    got_q.delete();
    send(1, 10, 1'b0);
    send(1, 20, 1'b0);
    send(1, 30, 1'b0);
    send(1, 40, 1'b1);
    send(1, 50, 1'b0);
    drain();
    e = '{10, 30, 60, 40, 90};
`ifndef FIR4_SCHED_AVG_EN
    cmp_list("clr", e);
`endif

    // Reset with both pipeline stages occupied
    set_data(0, 9);
    in_valid = 4'b0001;
    repeat (3) tick();
    do_reset();
    got_q.delete();
    send(0, 5, 1'b0);
    send(0, 5, 1'b0);
    drain();
    e = '{5, 10};
`ifndef FIR4_SCHED_AVG_EN
    cmp_list("rst", e);
`endif

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
